csr_uart_tx_fifo: RTL and testbench
===================================

CSR_UART_TX_FIFO -- requirements
Module: csr_uart_tx_fifo

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'hBC4, CSR address of the data/status register.
REQ-002 SHALL have parameter CLOCK_RATE, default 10000, clock frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 2500, serial bit rate; CLOCK_RATE/BAUD_RATE >= 2.
REQ-004 SHALL have parameter DEPTH_LOG2, default 3, FIFO depth = 2**DEPTH_LOG2 bytes.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port read  input  1  CSR read strobe.
REQ-008 SHALL have port write  input  1  CSR write strobe.
REQ-009 SHALL have port wdata  input  32  CSR write data.
REQ-010 SHALL have port addr  input  12  CSR address.
REQ-011 SHALL have port rdata  output  32  CSR read data, zero when not addressed (OR-combined bus).
REQ-012 SHALL have port valid  output  1  combinational addr==BASE_ADDR, or addr==BASE_ADDR+1 with IRQ feature.
REQ-013 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-014 Write to BASE_ADDR with FIFO not full SHALL push wdata[7:0]; upper bits ignored.
REQ-015 Write when full SHALL drop the byte and set sticky overflow flag; full evaluated on pre-pop count, even if a pop occurs the same cycle.
REQ-016 Simultaneous push (not full) and pop SHALL leave count unchanged and preserve order.
REQ-017 Read of BASE_ADDR SHALL return, registered one cycle later: bit0 full, bit1 empty, bit2 overflow, bits[DEPTH_LOG2+8:8] count; other bits zero.
REQ-018 Status read SHALL clear overflow in the same edge that registers rdata; an overflow set that cycle SHALL persist.
REQ-019 rdata SHALL be zero in any cycle not following an addressed read.
REQ-020 Transmit FSM states IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty, popping the head byte that cycle.
REQ-021 Each of START, 8 DATA bits (LSB first), STOP SHALL last exactly CLOCK_RATE/BAUD_RATE cycles (integer division); tx=0 in START, data bit in DATA, 1 in STOP/IDLE.
REQ-022 STOP->START directly (no idle cycle) if FIFO non-empty at end of STOP, else STOP->IDLE.
REQ-023 Push into empty FIFO while IDLE SHALL drive tx low exactly 2 cycles after the write edge.
REQ-024 Bit counter and baud counter SHALL wrap to zero only on state transition; FIFO pointers wrap modulo depth.
REQ-025 Writes to other addresses SHALL have no effect.

Reset
REQ-026 rst SHALL force FSM IDLE, tx=1, FIFO empty, count 0, overflow 0, rdata 0, counters 0.
REQ-027 rst mid-frame SHALL abort the frame; tx high on the cycle after the reset edge; queued bytes discarded.

Configuration
REQ-028 Macro CSR_UART_TX_FIFO_IRQ_EN SHALL add output irq (1 bit) and register BASE_ADDR+1 (bit0 irq enable, reset 0, readable with same latency).
REQ-029 With macro: irq = enable & (count <= depth/2), registered; without macro: no irq port, BASE_ADDR+1 not decoded, valid low there.

Structure
REQ-030 Package csr_uart_pkg SHALL hold FSM state encodings and status bit positions (FULL, EMPTY, OVF, COUNT_LSB).
REQ-031 FIFO storage SHALL be sub-module fifo_sync (width 8, DEPTH_LOG2 parameter, push/pop/full/empty/count).

Verification (CLOCK_RATE 10000, BAUD_RATE 2500, 4 cycles/bit, DEPTH_LOG2 3)
REQ-032 Write 0x41 while idle -> tx low 2 cycles later for 4 cycles, bits 1,0,0,0,0,0,1,0, stop high; frame 40 cycles.
REQ-033 Write 0x55, 0xAA back-to-back -> two frames with no idle cycle between; status then reads empty=1, count 0.
REQ-034 Write 10 bytes in 10 cycles -> first pops at once, 8 queued, 10th dropped; status read: full=1, overflow=1; second read overflow=0.
REQ-035 Assert rst at cycle 15 of a frame -> tx=1 next cycle, status reads empty=1, count 0, overflow 0.
REQ-036 Read addr BASE_ADDR-1 -> valid=0, rdata=0 next cycle; write there -> no push.
REQ-037 With CSR_UART_TX_FIFO_IRQ_EN: write 1 to BASE_ADDR+1, push 6 bytes -> irq low once count 5, high again once count drains to 4.

Source files
------------

// File: rtl/csr_uart_pkg.sv
// Shared encodings for the CSR-mapped UART transmitter: FSM states and status bit positions.
package csr_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned STAT_FULL      = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_OVF       = 2;
  localparam int unsigned STAT_COUNT_LSB = 8;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count; push is ignored when full, pop when empty.
module fifo_sync #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers are exactly DEPTH_LOG2 wide, so they wrap modulo depth for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count and pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/csr_uart_tx_fifo.sv
// CSR-mapped UART transmitter with byte FIFO and sticky overflow status.
// Optional macro CSR_UART_TX_FIFO_IRQ_EN adds an irq output and an enable register at BASE_ADDR+1.
module csr_uart_tx_fifo
  import csr_uart_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR  = 12'hBC4,
  parameter int          CLOCK_RATE = 10000,
  parameter int          BAUD_RATE  = 2500,
  parameter int          DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        tx
`ifdef CSR_UART_TX_FIFO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CYCLES_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int BAUD_W         = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CYCLES_PER_BIT - 1);
  localparam int CNT_W          = DEPTH_LOG2 + 1;

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        data_q, data_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       status;

  logic              sel_data, status_rd, data_wr, pop, baud_end;
  logic [7:0]        fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              unused_wdata;

  assign sel_data     = (addr == BASE_ADDR);
  assign status_rd    = read & sel_data;
  assign data_wr      = write & sel_data;
  assign baud_end     = (baud_q == BAUD_LAST);
  assign unused_wdata = ^wdata[31:8];

  fifo_sync #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (data_wr),
    .pop_i   (pop),
    .wdata_i (wdata[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_START;
          pop     = 1'b1;
          data_d  = fifo_rdata;
          baud_d  = '0;
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Back-to-back frames: chain straight into the next start bit.
          if (!fifo_empty) begin
            state_d = ST_START;
            pop     = 1'b1;
            data_d  = fifo_rdata;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line is registered from the current state, so it trails the state by one cycle.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = data_q[bit_q];
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    status                                 = '0;
    status[STAT_FULL]                      = fifo_full;
    status[STAT_EMPTY]                     = fifo_empty;
    status[STAT_OVF]                       = ovf_q;
    status[STAT_COUNT_LSB +: CNT_W]        = fifo_count;
  end

  // A drop in the same cycle as a clearing read still wins.
  assign ovf_d = (ovf_q & ~status_rd) | (data_wr & fifo_full);

`ifdef CSR_UART_TX_FIFO_IRQ_EN
  localparam logic [11:0]      IRQ_ADDR = BASE_ADDR + 12'd1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((1 << DEPTH_LOG2) / 2);

  logic sel_irq, irq_en_q, irq_en_d, irq_q;

  assign sel_irq  = (addr == IRQ_ADDR);
  assign valid    = sel_data | sel_irq;
  assign irq_en_d = (write & sel_irq) ? wdata[0] : irq_en_q;
  assign irq      = irq_q;

  always_comb begin
    rdata_d = '0;
    if (status_rd)          rdata_d = status;
    else if (read & sel_irq) rdata_d = {31'b0, irq_en_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_en_q & (fifo_count <= HALF_CNT);
    end
  end
`else
  assign valid = sel_data;

  always_comb begin
    rdata_d = '0;
    if (status_rd) rdata_d = status;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  assign tx    = tx_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_csr_uart_tx_fifo.sv
// Directed bench for csr_uart_tx_fifo: CSR decode table plus frame, overflow, reset and irq sequences.
module tb_csr_uart_tx_fifo;

  localparam logic [11:0] BASE = 12'hBC4;

  logic        clk = 1'b0;
  logic        rst, read, write;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid, tx;
`ifdef CSR_UART_TX_FIFO_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  csr_uart_tx_fifo dut (
    .clk   (clk),
    .rst   (rst),
    .read  (read),
    .write (write),
    .wdata (wdata),
    .addr  (addr),
    .rdata (rdata),
    .valid (valid),
    .tx    (tx)
`ifdef CSR_UART_TX_FIFO_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [11:0] a;
    logic [31:0] wd;
    logic        exp_valid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    read  = 1'b0;
    write = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic do_reset();
    idle_bus();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic status_read(input string name, input logic [31:0] exp);
    addr = BASE;
    read = 1'b1;
    step();
    idle_bus();
    check(name, rdata, exp);
  endtask

  // Expected line level for cycle idx (0..39) of a frame at 4 cycles per bit.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    int k;
    k = idx / 4;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic       saw_low;
    logic       seen;

    rst = 1'b1;
    idle_bus();
    step();
    step();
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_rdata", rdata, 32'h0);
    rst = 1'b0;

    // CSR decode table from the reset state.
    vecs[0]  = '{1'b1, 1'b0, BASE,          32'h0,  1'b1, 32'h2};
    vecs[1]  = '{1'b1, 1'b0, BASE - 12'd1,  32'h0,  1'b0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, BASE - 12'd1,  32'h12, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, BASE,          32'h0,  1'b1, 32'h2};
    vecs[4]  = '{1'b0, 1'b0, BASE,          32'h0,  1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 12'h000,       32'h0,  1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 12'hBC3,       32'hFF, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, BASE,          32'h0,  1'b1, 32'h2};
    vecs[8]  = '{1'b1, 1'b0, 12'hFFF,       32'h0,  1'b0, 32'h0};
`ifdef CSR_UART_TX_FIFO_IRQ_EN
    vecs[9]  = '{1'b1, 1'b0, BASE + 12'd1,  32'h0,  1'b1, 32'h0};
    vecs[10] = '{1'b0, 1'b1, BASE + 12'd1,  32'h76, 1'b1, 32'h0};
`else
    vecs[9]  = '{1'b1, 1'b0, BASE + 12'd1,  32'h0,  1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, BASE + 12'd1,  32'h76, 1'b0, 32'h0};
`endif
    vecs[11] = '{1'b1, 1'b0, BASE,          32'h0,  1'b1, 32'h2};

    for (int i = 0; i < 12; i++) begin
      read  = vecs[i].rd;
      write = vecs[i].wr;
      addr  = vecs[i].a;
      wdata = vecs[i].wd;
      #1;
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      step();
      idle_bus();
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
    end
    check("idle_tx_after_table", 32'(tx), 32'h1);

    // Single frame; upper write-data bits must be ignored.
    addr  = BASE;
    wdata = 32'hFFFF_FF41;
    write = 1'b1;
    step();
    idle_bus();
    step();
    check("a_tx_before_start", 32'(tx), 32'h1);
    for (int i = 0; i < 40; i++) begin
      step();
      check($sformatf("a_tx_%0d", i), 32'(tx), 32'(frame_bit(8'h41, i)));
    end
    step();
    check("a_tx_idle_after", 32'(tx), 32'h1);

    // Back-to-back bytes: push and pop collide on the second write, frames abut.
    addr  = BASE;
    wdata = 32'h55;
    write = 1'b1;
    step();
    wdata = 32'hAA;
    step();
    idle_bus();
    for (int i = 0; i < 80; i++) begin
      b = (i < 40) ? 8'h55 : 8'hAA;
      step();
      check($sformatf("b_tx_%0d", i), 32'(tx), 32'(frame_bit(b, i % 40)));
    end
    step();
    status_read("b_status_empty", 32'h2);

    // Ten writes in ten cycles: one in flight, eight queued, tenth dropped.
    for (int i = 0; i < 10; i++) begin
      addr  = BASE;
      wdata = 32'h30 + 32'(i);
      write = 1'b1;
      step();
    end
    idle_bus();
    status_read("c_status_full_ovf", 32'h805);
    status_read("c_status_ovf_cleared", 32'h801);
    // Clearing read and dropped write in the same cycle: overflow must survive.
    addr  = BASE;
    read  = 1'b1;
    write = 1'b1;
    wdata = 32'h99;
    step();
    idle_bus();
    check("c_read_with_drop", rdata, 32'h801);
    status_read("c_ovf_persists", 32'h805);
    do_reset();
    check("c_tx_after_reset", 32'(tx), 32'h1);
    status_read("c_status_after_reset", 32'h2);

    // Reset in the middle of an all-zero frame with a byte queued behind it.
    addr  = BASE;
    wdata = 32'h00;
    write = 1'b1;
    step();
    wdata = 32'hFF;
    step();
    idle_bus();
    repeat (14) step();
    check("d_tx_mid_frame", 32'(tx), 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("d_tx_after_rst", 32'(tx), 32'h1);
    status_read("d_status_after_rst", 32'h2);
    saw_low = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("d_no_frame_after_rst", 32'(saw_low), 32'h0);

`ifdef CSR_UART_TX_FIFO_IRQ_EN
    check("e_irq_disabled", 32'(irq), 32'h0);
    addr  = BASE + 12'd1;
    wdata = 32'h1;
    write = 1'b1;
    step();
    idle_bus();
    addr = BASE + 12'd1;
    read = 1'b1;
    step();
    idle_bus();
    check("e_irq_en_readback", rdata, 32'h1);
    check("e_irq_high_empty", 32'(irq), 32'h1);
    for (int i = 0; i < 6; i++) begin
      addr  = BASE;
      wdata = 32'h60 + 32'(i);
      write = 1'b1;
      step();
    end
    idle_bus();
    step();
    check("e_irq_low_at_5", 32'(irq), 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (irq === 1'b1) seen = 1'b1;
    end
    check("e_irq_rise_seen", 32'(seen), 32'h1);
    status_read("e_status_count_4", 32'h400);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
